// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller:
// in-flight tag layout, forward-select encoding and default depths.
package pipe_pkg;

  localparam int TAG_RW         = 8;
  localparam int DEF_STAGES     = 3;
  localparam int DEF_NREGS      = 16;
  localparam int DEF_ALU_STAGE  = 1;
  localparam int DEF_LOAD_STAGE = 2;
  localparam int DEF_CNT_W      = 32;

  localparam int FWD_RF = 0;

  // dst is sized for the largest register file; narrower files zero-extend
  typedef struct packed {
    logic              valid;
    logic [TAG_RW-1:0] dst;
    logic              wr;
    logic              is_load;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '0;

  function automatic int ready_stage(
    input logic is_load,
    input int   alu_s,
    input int   load_s
  );
    return is_load ? load_s : alu_s;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle of the hazard controller: operand/destination
// description in, issue stall and registered forward selects out.
interface pipe_hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int STAGES = DEF_STAGES
);

  localparam int RW = $clog2(NREGS);
  localparam int FW = $clog2(STAGES);

  logic          d_valid;
  logic          d_kill;
  logic [RW-1:0] d_src1;
  logic [RW-1:0] d_src2;
  logic          d_src1_used;
  logic          d_src2_used;
  logic [RW-1:0] d_dst;
  logic          d_wr;
  logic          d_is_load;
  logic          issue_stall;
  logic [FW-1:0] x_fwd_a;
  logic [FW-1:0] x_fwd_b;

  modport master (
    output d_valid,
    output d_kill,
    output d_src1,
    output d_src2,
    output d_src1_used,
    output d_src2_used,
    output d_dst,
    output d_wr,
    output d_is_load,
    input  issue_stall,
    input  x_fwd_a,
    input  x_fwd_b
  );

  modport slave (
    input  d_valid,
    input  d_kill,
    input  d_src1,
    input  d_src2,
    input  d_src1_used,
    input  d_src2_used,
    input  d_dst,
    input  d_wr,
    input  d_is_load,
    output issue_stall,
    output x_fwd_a,
    output x_fwd_b
  );

endinterface

// File: rtl/pipe_hazard_ctrl_tag_pipe.sv
// Shift register of in-flight instruction tags past decode.
// Freezes on memory stall; a bubble enters stage 0 when nothing issues.
module hazard_tag_pipe
  import pipe_pkg::*;
#(
  parameter int STAGES = DEF_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze_i,
  input  logic              push_i,
  input  tag_t              tag_i,
  output tag_t [STAGES-1:0] tags_o
);

  tag_t [STAGES-1:0] tags_q;
  tag_t [STAGES-1:0] tags_d;

  always_comb begin
    tags_d = tags_q;
    if (!freeze_i) begin
      tags_d[0] = push_i ? tag_i : TAG_BUBBLE;
      for (int k = 1; k < STAGES; k++) begin
        tags_d[k] = tags_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags_q <= '0;
    end else begin
      tags_q <= tags_d;
    end
  end

  assign tags_o = tags_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall and registered operand forwarding for an in-order
// pipeline of configurable depth and per-class result latency.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int STAGES     = DEF_STAGES,
  parameter int NREGS      = DEF_NREGS,
  parameter int ALU_STAGE  = DEF_ALU_STAGE,
  parameter int LOAD_STAGE = DEF_LOAD_STAGE,
  parameter bit ZERO_REG   = 1'b1,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_stall,
  pipe_hazard_ctrl_if.slave    dif,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     issue_cnt
);

  localparam int RW = $clog2(NREGS);
  localparam int FW = $clog2(STAGES);

  if (STAGES < 2) begin : g_bad_stages
    $error("pipe_hazard_ctrl: STAGES must be at least 2");
  end
  if (ALU_STAGE < 0 || ALU_STAGE >= STAGES) begin : g_bad_alu
    $error("pipe_hazard_ctrl: ALU_STAGE out of range");
  end
  if (LOAD_STAGE < ALU_STAGE || LOAD_STAGE >= STAGES) begin : g_bad_load
    $error("pipe_hazard_ctrl: need ALU_STAGE <= LOAD_STAGE < STAGES");
  end
  if (RW > TAG_RW) begin : g_bad_nregs
    $error("pipe_hazard_ctrl: NREGS exceeds tag width");
  end

  typedef struct packed {
    logic          haz;
    logic [FW-1:0] sel;
  } res_t;

  tag_t [STAGES-1:0] tags;
  tag_t              in_tag;
  res_t              r1;
  res_t              r2;
  logic              live;
  logic              hazard;
  logic              issue;

  logic [FW-1:0]    fwd_a_q, fwd_a_d;
  logic [FW-1:0]    fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

  function automatic logic producer(
    input tag_t          t,
    input logic [RW-1:0] src,
    input logic          used
  );
    logic is_zero;
    is_zero = ZERO_REG && (t.dst == '0);
    return t.valid && t.wr && used &&
           (t.dst == TAG_RW'(src)) && !is_zero;
  endfunction

  // Walk oldest to youngest so the youngest producer wins.
  function automatic res_t resolve(
    input tag_t [STAGES-1:0] t,
    input logic [RW-1:0]     src,
    input logic              used
  );
    res_t r;
    int   nxt;
    int   rdy;
    r = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      if (producer(t[k], src, used)) begin
        nxt   = k + 1;
        rdy   = ready_stage(t[k].is_load, ALU_STAGE, LOAD_STAGE);
        r.haz = (nxt < rdy);
        // past the last tracked stage the RF write-through covers it
        if (!r.haz && nxt <= STAGES-1) begin
          r.sel = FW'(nxt);
        end else begin
          r.sel = FW'(FWD_RF);
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    r1 = resolve(tags, dif.d_src1, dif.d_src1_used);
    r2 = resolve(tags, dif.d_src2, dif.d_src2_used);
  end

  assign live   = dif.d_valid && !dif.d_kill;
  assign hazard = r1.haz || r2.haz;
  assign issue  = live && !hazard;

  assign dif.issue_stall = live && hazard;

  assign in_tag = '{
    valid:   1'b1,
    dst:     TAG_RW'(dif.d_dst),
    wr:      dif.d_wr,
    is_load: dif.d_is_load
  };

  hazard_tag_pipe #(
    .STAGES (STAGES)
  ) u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .freeze_i (mem_stall),
    .push_i   (issue),
    .tag_i    (in_tag),
    .tags_o   (tags)
  );

  always_comb begin
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    issue_cnt_d = issue_cnt_q;
    if (!mem_stall) begin
      fwd_a_d = issue ? r1.sel : FW'(FWD_RF);
      fwd_b_d = issue ? r2.sel : FW'(FWD_RF);
      if (dif.issue_stall && stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (issue && issue_cnt_q != '1) begin
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q     <= FW'(FWD_RF);
      fwd_b_q     <= FW'(FWD_RF);
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign dif.x_fwd_a = fwd_a_q;
  assign dif.x_fwd_b = fwd_b_q;
  assign stall_cnt   = stall_cnt_q;
  assign issue_cnt   = issue_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default, ZERO_REG=0 and
// five-stage instances share one decode stimulus stream.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       mem_stall;
  logic       d_valid;
  logic       d_kill;
  logic [3:0] d_src1;
  logic [3:0] d_src2;
  logic       d_src1_used;
  logic       d_src2_used;
  logic [3:0] d_dst;
  logic       d_wr;
  logic       d_is_load;

  logic [31:0] stall_cnt0, issue_cnt0;
  logic [31:0] stall_cntz, issue_cntz;
  logic [31:0] stall_cnt5, issue_cnt5;

  int n_chk;
  int n_fail;

  pipe_hazard_ctrl_if #(.NREGS(16), .STAGES(3)) if0 ();
  pipe_hazard_ctrl_if #(.NREGS(16), .STAGES(3)) ifz ();
  pipe_hazard_ctrl_if #(.NREGS(16), .STAGES(5)) if5 ();

  assign if0.d_valid     = d_valid;
  assign if0.d_kill      = d_kill;
  assign if0.d_src1      = d_src1;
  assign if0.d_src2      = d_src2;
  assign if0.d_src1_used = d_src1_used;
  assign if0.d_src2_used = d_src2_used;
  assign if0.d_dst       = d_dst;
  assign if0.d_wr        = d_wr;
  assign if0.d_is_load   = d_is_load;

  assign ifz.d_valid     = d_valid;
  assign ifz.d_kill      = d_kill;
  assign ifz.d_src1      = d_src1;
  assign ifz.d_src2      = d_src2;
  assign ifz.d_src1_used = d_src1_used;
  assign ifz.d_src2_used = d_src2_used;
  assign ifz.d_dst       = d_dst;
  assign ifz.d_wr        = d_wr;
  assign ifz.d_is_load   = d_is_load;

  assign if5.d_valid     = d_valid;
  assign if5.d_kill      = d_kill;
  assign if5.d_src1      = d_src1;
  assign if5.d_src2      = d_src2;
  assign if5.d_src1_used = d_src1_used;
  assign if5.d_src2_used = d_src2_used;
  assign if5.d_dst       = d_dst;
  assign if5.d_wr        = d_wr;
  assign if5.d_is_load   = d_is_load;

  pipe_hazard_ctrl u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_stall (mem_stall),
    .dif       (if0),
    .stall_cnt (stall_cnt0),
    .issue_cnt (issue_cnt0)
  );

  pipe_hazard_ctrl #(.ZERO_REG(1'b0)) u_dutz (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_stall (mem_stall),
    .dif       (ifz),
    .stall_cnt (stall_cntz),
    .issue_cnt (issue_cntz)
  );

  pipe_hazard_ctrl #(.STAGES(5), .LOAD_STAGE(3)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_stall (mem_stall),
    .dif       (if5),
    .stall_cnt (stall_cnt5),
    .issue_cnt (issue_cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(
    input logic       v,
    input logic       kill,
    input logic [3:0] s1,
    input logic       u1,
    input logic [3:0] s2,
    input logic       u2,
    input logic [3:0] dst,
    input logic       wr,
    input logic       ld
  );
    d_valid     = v;
    d_kill      = kill;
    d_src1      = s1;
    d_src1_used = u1;
    d_src2      = s2;
    d_src2_used = u2;
    d_dst       = dst;
    d_wr        = wr;
    d_is_load   = ld;
    #1;
  endtask

  task automatic idle();
    op(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input logic [3:0] dst);
    op(1, 0, 0, 0, 0, 0, dst, 1, 0);
  endtask

  task automatic ld(input logic [3:0] dst);
    op(1, 0, 0, 0, 0, 0, dst, 1, 1);
  endtask

  task automatic use1(input logic [3:0] s);
    op(1, 0, s, 1, 0, 0, 4'd15, 1, 0);
  endtask

  task automatic use2(input logic [3:0] s);
    op(1, 0, 0, 0, s, 1, 4'd15, 1, 0);
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    mem_stall = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(if0.issue_stall), 0);
    chk("rst_fwd_a", 32'(if0.x_fwd_a), 0);
    chk("rst_fwd_b", 32'(if0.x_fwd_b), 0);
    chk("rst_stall_cnt", stall_cnt0, 0);
    chk("rst_issue_cnt", issue_cnt0, 0);
    rst_n = 1'b1;

    // ALU -> ALU back to back
    alu(1);
    chk("t1_alu_stall", 32'(if0.issue_stall), 0);
    step();
    op(1, 0, 1, 1, 5, 1, 15, 1, 0);
    chk("t1_use_stall", 32'(if0.issue_stall), 0);
    step();
    chk("t1_fwd_a", 32'(if0.x_fwd_a), 1);
    chk("t1_fwd_b", 32'(if0.x_fwd_b), 0);

    // load-use: one stall cycle, then forward from stage 2
    drain();
    chk("t2_drain_fwd_a", 32'(if0.x_fwd_a), 0);
    ld(2);
    step();
    use2(2);
    chk("t2_stall", 32'(if0.issue_stall), 1);
    step();
    chk("t2_stall_cnt", stall_cnt0, 1);
    chk("t2_bubble_fwd_b", 32'(if0.x_fwd_b), 0);
    chk("t2_release", 32'(if0.issue_stall), 0);
    step();
    chk("t2_fwd_b", 32'(if0.x_fwd_b), 2);
    chk("t2_issue_cnt", issue_cnt0, 4);
    chk("t2_stall_cnt_after", stall_cnt0, 1);

    // youngest producer wins; stage-2 producer falls back to RF
    drain();
    alu(3);
    step();
    alu(3);
    step();
    use1(3);
    chk("t3_stall", 32'(if0.issue_stall), 0);
    step();
    chk("t3_youngest", 32'(if0.x_fwd_a), 1);
    drain();
    alu(3);
    step();
    idle();
    step();
    step();
    use1(3);
    chk("t3_old_stall", 32'(if0.issue_stall), 0);
    step();
    chk("t3_old_rf", 32'(if0.x_fwd_a), 0);

    // R0 producer: ignored only when hardwired zero
    drain();
    alu(0);
    step();
    use1(0);
    chk("t4_r0_stall", 32'(if0.issue_stall), 0);
    chk("t4_r0_stall_z", 32'(ifz.issue_stall), 0);
    step();
    chk("t4_r0_fwd", 32'(if0.x_fwd_a), 0);
    chk("t4_r0_fwd_z", 32'(ifz.x_fwd_a), 1);
    ld(0);
    step();
    use2(0);
    chk("t4_r0_ld_stall", 32'(if0.issue_stall), 0);
    chk("t4_r0_ld_stall_z", 32'(ifz.issue_stall), 1);
    step();
    chk("t4_r0_ld_fwd", 32'(if0.x_fwd_b), 0);

    // load-use under a 4-cycle memory stall
    drain();
    alu(5);
    step();
    op(1, 0, 5, 1, 0, 0, 6, 1, 1);
    step();
    chk("t5_pre_fwd_a", 32'(if0.x_fwd_a), 1);
    chk("t5_pre_issue_cnt", issue_cnt0, 15);
    mem_stall = 1'b1;
    use2(6);
    chk("t5_frz_stall0", 32'(if0.issue_stall), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_frz_stall", 32'(if0.issue_stall), 1);
      chk("t5_frz_fwd_a", 32'(if0.x_fwd_a), 1);
      chk("t5_frz_stall_cnt", stall_cnt0, 1);
      chk("t5_frz_issue_cnt", issue_cnt0, 15);
    end
    mem_stall = 1'b0;
    #1;
    chk("t5_rel_stall", 32'(if0.issue_stall), 1);
    step();
    chk("t5_rel_stall_cnt", stall_cnt0, 2);
    chk("t5_rel_fwd_a", 32'(if0.x_fwd_a), 0);
    chk("t5_rel_go", 32'(if0.issue_stall), 0);
    step();
    chk("t5_rel_fwd_b", 32'(if0.x_fwd_b), 2);
    chk("t5_rel_issue_cnt", issue_cnt0, 16);

    // squash during a hazard: no stall, bubble inserted
    ld(7);
    step();
    op(1, 1, 7, 1, 0, 0, 9, 1, 0);
    chk("t5_kill_stall", 32'(if0.issue_stall), 0);
    step();
    chk("t5_kill_issue_cnt", issue_cnt0, 17);
    chk("t5_kill_stall_cnt", stall_cnt0, 2);
    op(1, 0, 7, 1, 0, 0, 9, 1, 0);
    chk("t5_after_kill_stall", 32'(if0.issue_stall), 0);
    step();
    chk("t5_after_kill_fwd", 32'(if0.x_fwd_a), 2);

    // async reset in the middle of a frozen hazard
    op(1, 0, 0, 0, 9, 1, 8, 1, 1);
    step();
    chk("t6_pre_fwd_b", 32'(if0.x_fwd_b), 1);
    mem_stall = 1'b1;
    use1(8);
    chk("t6_pre_stall", 32'(if0.issue_stall), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_stall", 32'(if0.issue_stall), 0);
    chk("t6_rst_fwd_b", 32'(if0.x_fwd_b), 0);
    chk("t6_rst_stall_cnt", stall_cnt0, 0);
    chk("t6_rst_issue_cnt", issue_cnt0, 0);
    mem_stall = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;

    // five stages, loads ready at stage 3: two stall cycles
    ld(10);
    step();
    use1(10);
    chk("t6_s5_stall0", 32'(if5.issue_stall), 1);
    step();
    chk("t6_s5_stall1", 32'(if5.issue_stall), 1);
    step();
    chk("t6_s5_go", 32'(if5.issue_stall), 0);
    chk("t6_s5_stall_cnt", stall_cnt5, 2);
    step();
    chk("t6_s5_fwd_a", 32'(if5.x_fwd_a), 3);
    chk("t6_s5_issue_cnt", issue_cnt5, 2);

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the in-order pipeline. Tracks the destination of every in-flight instruction past decode and generates the decode-stage load-use stall. Produces registered forwarding selects for the operands of the instruction entering execute. Generalises the fixed three-stage X/M/W forwarding and hazard logic to configurable depth, register count and per-class result latency, and adds freeze-on-memory-stall, squash and performance counters.

## Interface
- `STAGES`, 3: number of tracked stages after decode (stage 0 = execute, stage STAGES-1 = writeback).
- `NREGS`, 16: architectural register count; `RW = $clog2(NREGS)`.
- `ALU_STAGE`, 1: first stage index holding a valid ALU result.
- `LOAD_STAGE`, 2: first stage index holding valid load data (LOAD_STAGE >= ALU_STAGE, < STAGES).
- `ZERO_REG`, 1: register 0 is hardwired zero and is never a producer.
- `CNT_W`, 32: performance counter width.
- `clk  in  1`: clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `d_valid  in  1`: decode holds a real instruction.
- `d_kill  in  1`: squash the decode instruction (taken branch); it becomes a bubble.
- `d_src1, d_src2  in  RW`: decode source registers.
- `d_src1_used, d_src2_used  in  1`: the source is actually read.
- `d_dst  in  RW`: decode destination.
- `d_wr  in  1`: decode instruction writes `d_dst`.
- `d_is_load  in  1`: decode instruction is a load.
- `mem_stall  in  1`: cache stall; freezes all state.
- `issue_stall  out  1`: combinational; hold F/D and insert bubble.
- `x_fwd_a, x_fwd_b  out  $clog2(STAGES)`: registered; 0 = register-file value, s>0 = result of stage s.
- `stall_cnt, issue_cnt  out  CNT_W`: saturating counters.

## Operation
- Per-stage tag: valid, dst, wr, is_load. Producer match at stage k: valid & wr & dst == src & src_used & ~(ZERO_REG & dst == 0).
- Youngest match (lowest k) governs each source; older matches are ignored.
- Ready stage r = is_load ? LOAD_STAGE : ALU_STAGE. After issue the producer sits at k+1.
- Hazard if k+1 < r. `issue_stall` = d_valid & ~d_kill & (hazard on src1 | hazard on src2).
- Forward select for a non-hazard source: k+1 if k+1 <= STAGES-1; otherwise 0 (covered by register-file write-through). No match gives 0.
- issue = d_valid & ~d_kill & ~issue_stall.

## Timing
- On a rising clk with ~mem_stall:
  - tag[k+1] <= tag[k].
  - tag[0] <= issue ? {1, d_dst, d_wr, d_is_load} : bubble (valid = 0).
  - x_fwd_a/b <= issue ? computed selects : 0.
- With mem_stall = 1, tags, fwd registers and counters all hold. `issue_stall` remains combinationally valid.
- d_kill with a hazard present: no stall; a bubble is inserted.
- Latency: a load-use hazard costs LOAD_STAGE-ALU_STAGE stall cycles (1 by default). ALU-to-ALU costs 0.
- Counters (advance only when ~mem_stall, saturate at all-ones):
  - stall_cnt += d_valid & ~d_kill & issue_stall.
  - issue_cnt += issue.
- Reset (async, any time, including mid-stall): all tag valids 0, x_fwd_a/b = 0, counters 0. `issue_stall` is then 0 because no producers exist.

## Structure
- Shared package `pipe_pkg` holds:
  - the tag struct (valid, dst, wr, is_load);
  - fwd-select encoding constants (FWD_RF = 0);
  - default stage constants.
- Sub-module `hazard_tag_pipe`: parametrised tag shift register with freeze and bubble insertion. Comparison, priority and counters stay in the top.
- Elaboration-time assertions on parameter ordering.

## Test plan
Defaults are used throughout.
1. ALU op writing R1 issues; next cycle decode reads R1 as src1 -> issue_stall=0; following cycle x_fwd_a=1.
2. Load to R2 issues; next cycle decode reads R2 as src2 -> issue_stall=1 for exactly 1 cycle, stall_cnt=1; then issue with x_fwd_b=2.
3. R3 written by instruction at stage 1 and by a newer one at stage 0; decode reads R3 -> x_fwd_a=1 (youngest). With only the stage-2 producer present -> x_fwd_a=0.
4. Producer dst=R0, d_wr=1, decode reads R0 -> no stall, x_fwd=0. Repeat with ZERO_REG=0 -> x_fwd=1.
5. Load-use hazard with mem_stall high for 4 cycles -> tags, x_fwd and counters frozen, issue_stall held at 1; after release exactly 1 stall cycle counted. d_kill during a hazard -> no stall, bubble inserted.
6. Assert rst_n low mid-stall -> outputs and counters 0 immediately. Run STAGES=5, LOAD_STAGE=3: load-use -> 2 stall cycles, then x_fwd=3.
